// File: rtl/fifo_axis_rd_adapter.sv
// fifo_axis_rd_adapter
//
// Read-side drain engine for the RX packet FIFO. It pops words from a
// non-FWFT FIFO, where read data is valid one cycle after the read enable,
// and presents them as an AXI-Stream master to the downstream UDP/IP parser.
// A 2-entry output buffer lets the stream sustain one beat per cycle while
// still absorbing backpressure. Everything runs in the FIFO read clock domain.
//
// Parameters:
//   DATA_WIDTH : payload width. The FIFO word is DATA_WIDTH+1 bits wide and
//                its MSB is tlast.
//   CNT_WIDTH  : width of the completed-packet counter.
//
// Ports:
//   clk           in   read-domain clock
//   reset         in   asynchronous, active-high reset
//   fifo_rd_en    out  FIFO pop (combinational)
//   fifo_rd_data  in   FIFO word, valid the cycle after fifo_rd_en
//   fifo_empty    in   FIFO empty flag
//   m_axis_tdata  out  stream data
//   m_axis_tlast  out  end of packet
//   m_axis_tvalid out  stream valid
//   m_axis_tready in   downstream ready
//   pkt_count     out  completed packets (modulo 2^CNT_WIDTH)
//
// Build option:
//   ADAPTER_PKT_CNT_EN : when defined, pkt_count counts popped beats that
//                        carry tlast. When undefined, pkt_count is tied to 0.
//                        The port exists in both builds.
module fifo_axis_rd_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH:0]   fifo_rd_data,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  logic [1:0]          cnt;
  logic                inflight;
  logic                head;
  logic                tail;
  logic [DATA_WIDTH:0] entry [2];
  logic                pop;
  logic [2:0]          pending;

  assign m_axis_tvalid = (cnt != 2'd0);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = entry[head][DATA_WIDTH-1:0];
  assign m_axis_tlast  = entry[head][DATA_WIDTH];

  // Words that will occupy the buffer after this edge, counting the word
  // still in flight from the FIFO. A new read is issued only if its data is
  // guaranteed a free slot when it arrives. Subtracting pop here keeps the
  // pipeline full at one beat per cycle. cnt is never 0 while pop is high,
  // so the subtraction cannot underflow.
  assign pending    = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !fifo_empty && !reset && (pending < 3'd2);

  // The FIFO presents the word one cycle after the read, so inflight marks
  // exactly the cycles in which fifo_rd_data must be captured. The capture
  // happens even if the FIFO has gone empty since the read was issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      entry[0] <= '0;
      entry[1] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        entry[tail] <= fifo_rd_data;
        tail        <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({inflight, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef ADAPTER_PKT_CNT_EN
  logic [CNT_WIDTH-1:0] pkt_count_q;

  // Counts completed packets as the beat carrying tlast leaves the adapter.
  // The counter wraps naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_q <= '0;
    end else if (pop && m_axis_tlast) begin
      pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
    end
  end

  assign pkt_count = pkt_count_q;
`else
  assign pkt_count = '0;
`endif

endmodule
